// File: rtl/stopwatch_ctrl.sv
// Two-digit seconds stopwatch controller: button conditioning, IDLE/RUN/PAUSE/LAP
// state machine, count timebase, 00-59 BCD seconds with lap capture, digit outputs.

// One front-panel button: 2-flop synchronizer, level debouncer, rising-edge press.
module stopwatch_ctrl_btn #(
    parameter int unsigned DEB_CYCLES = 250000
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic btn_i,
    input  logic sync_vld_i,
    output logic press_o
);
    localparam int unsigned CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

    logic          meta_q;
    logic          sync_q;
    logic          deb_q;
    logic          deb_d;
    logic          deb_prev_q;
    logic          armed_q;
    logic          armed_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // A press is only honoured once the button has been seen released after reset,
    // so a button held through reset release never produces an event.
    always_comb begin
        cnt_d   = cnt_q;
        deb_d   = deb_q;
        armed_d = armed_q | (sync_vld_i & ~sync_q);
        if (sync_q != deb_q) begin
            if (cnt_q == CNT_LAST) begin
                deb_d = sync_q;
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end else begin
            cnt_d = '0;
        end
    end

    // Synchronizer, debounce state and edge-detect history
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            meta_q     <= 1'b0;
            sync_q     <= 1'b0;
            deb_q      <= 1'b0;
            deb_prev_q <= 1'b0;
            armed_q    <= 1'b0;
            cnt_q      <= '0;
        end else begin
            meta_q     <= btn_i;
            sync_q     <= meta_q;
            deb_q      <= deb_d;
            deb_prev_q <= deb_q;
            armed_q    <= armed_d;
            cnt_q      <= cnt_d;
        end
    end

    assign press_o = deb_q & ~deb_prev_q & armed_q;
endmodule

module stopwatch_ctrl #(
    parameter int unsigned TICK_DIV   = 10000000,
    parameter int unsigned DEB_CYCLES = 250000
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       btn_ss_i,
    input  logic       btn_lc_i,
    output logic [3:0] disp_1_o,
    output logic [3:0] disp_10_o,
    output logic [1:0] state_o,
    output logic       run_led_o,
    output logic       tick_o,
    output logic       wrap_o
);
    localparam int unsigned PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_PAUSE = 2'b10,
        ST_LAP   = 2'b11
    } state_t;

    state_t        state_q;
    state_t        state_d;
    logic [1:0]    vld_q;
    logic          ss_press_s;
    logic          lc_press_s;
    logic          running_s;
    logic          tick_s;
    logic          clear_s;
    logic          capture_s;
    logic [PW-1:0] presc_q;
    logic [PW-1:0] presc_d;
    logic [3:0]    ones_q;
    logic [3:0]    ones_d;
    logic [3:0]    tens_q;
    logic [3:0]    tens_d;
    logic [3:0]    lap1_q;
    logic [3:0]    lap1_d;
    logic [3:0]    lap10_q;
    logic [3:0]    lap10_d;
    logic [3:0]    disp1_q;
    logic [3:0]    disp1_d;
    logic [3:0]    disp10_q;
    logic [3:0]    disp10_d;
    logic          run_led_q;
    logic          run_led_d;
    logic          tick_q;
    logic          wrap_q;
    logic          wrap_d;

    stopwatch_ctrl_btn #(.DEB_CYCLES(DEB_CYCLES)) u_btn_ss (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .btn_i      (btn_ss_i),
        .sync_vld_i (vld_q[1]),
        .press_o    (ss_press_s)
    );

    stopwatch_ctrl_btn #(.DEB_CYCLES(DEB_CYCLES)) u_btn_lc (
        .clk_i      (clk_i),
        .rst_n_i    (rst_n_i),
        .btn_i      (btn_lc_i),
        .sync_vld_i (vld_q[1]),
        .press_o    (lc_press_s)
    );

    assign running_s = (state_q == ST_RUN) || (state_q == ST_LAP);
    assign tick_s    = running_s && (presc_q == PRESC_LAST);

    // Next-state logic; start/stop has priority over lap/clear
    always_comb begin
        state_d   = state_q;
        clear_s   = 1'b0;
        capture_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (ss_press_s) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (ss_press_s) begin
                    state_d = ST_PAUSE;
                end else if (lc_press_s) begin
                    state_d   = ST_LAP;
                    capture_s = 1'b1;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_LAP: begin
                if (ss_press_s) begin
                    state_d = ST_PAUSE;
                end else if (lc_press_s) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_LAP;
                end
            end
            ST_PAUSE: begin
                if (ss_press_s) begin
                    state_d = ST_RUN;
                end else if (lc_press_s) begin
                    state_d = ST_IDLE;
                    clear_s = 1'b1;
                end else begin
                    state_d = ST_PAUSE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Prescaler, BCD seconds and lap capture (capture sees the pre-tick count)
    always_comb begin
        presc_d = presc_q;
        ones_d  = ones_q;
        tens_d  = tens_q;
        lap1_d  = lap1_q;
        lap10_d = lap10_q;
        wrap_d  = tick_s && (ones_q == 4'd9) && (tens_q == 4'd5);

        if (clear_s || (state_q == ST_IDLE)) begin
            presc_d = '0;
        end else if (tick_s) begin
            presc_d = '0;
        end else if (running_s) begin
            presc_d = presc_q + PW'(1);
        end else begin
            presc_d = presc_q;
        end

        if (clear_s) begin
            ones_d = 4'd0;
            tens_d = 4'd0;
        end else if (tick_s) begin
            if (ones_q == 4'd9) begin
                ones_d = 4'd0;
                if (tens_q == 4'd5) begin
                    tens_d = 4'd0;
                end else begin
                    tens_d = tens_q + 4'd1;
                end
            end else begin
                ones_d = ones_q + 4'd1;
            end
        end else begin
            ones_d = ones_q;
            tens_d = tens_q;
        end

        if (capture_s) begin
            lap1_d  = ones_q;
            lap10_d = tens_q;
        end else begin
            lap1_d  = lap1_q;
            lap10_d = lap10_q;
        end
    end

    // Display source and LED follow the state being entered
    always_comb begin
        run_led_d = (state_d == ST_RUN) || (state_d == ST_LAP);
        if (state_d == ST_LAP) begin
            disp1_d  = lap1_d;
            disp10_d = lap10_d;
        end else begin
            disp1_d  = ones_d;
            disp10_d = tens_d;
        end
    end

    // State, datapath and registered outputs
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= ST_IDLE;
            vld_q     <= 2'b00;
            presc_q   <= '0;
            ones_q    <= 4'd0;
            tens_q    <= 4'd0;
            lap1_q    <= 4'd0;
            lap10_q   <= 4'd0;
            disp1_q   <= 4'd0;
            disp10_q  <= 4'd0;
            run_led_q <= 1'b0;
            tick_q    <= 1'b0;
            wrap_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            vld_q     <= {vld_q[0], 1'b1};
            presc_q   <= presc_d;
            ones_q    <= ones_d;
            tens_q    <= tens_d;
            lap1_q    <= lap1_d;
            lap10_q   <= lap10_d;
            disp1_q   <= disp1_d;
            disp10_q  <= disp10_d;
            run_led_q <= run_led_d;
            tick_q    <= tick_s;
            wrap_q    <= wrap_d;
        end
    end

    assign state_o   = state_q;
    assign disp_1_o  = disp1_q;
    assign disp_10_o = disp10_q;
    assign run_led_o = run_led_q;
    assign tick_o    = tick_q;
    assign wrap_o    = wrap_q;
endmodule
